// File: rtl/bus_arb_pkg.sv
// Shared definitions for the round-robin bus arbiter slice.
package bus_arb_pkg;

    localparam int DEFAULT_NUM_CLIENTS = 4;
    localparam int DEFAULT_DATA_WIDTH  = 8;
    localparam int DEFAULT_ADDR_WIDTH  = 4;
    localparam int DEFAULT_TIMEOUT     = 15;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } arbState_e;

    // Bits needed to index 'value' items; never less than one bit.
    function automatic int clog2(input int value);
        int result;
        result = 1;
        while ((1 << result) < value) result++;
        return result;
    endfunction

endpackage

// File: rtl/rr_priority_sel.sv
// Combinational round-robin picker: first request at or above ptr_i, wrapping.
module rr_priority_sel
    import bus_arb_pkg::*;
#(
    parameter int NUM_REQ = DEFAULT_NUM_CLIENTS
)(
    input  logic [NUM_REQ-1:0]        req_i,
    input  logic [clog2(NUM_REQ)-1:0] ptr_i,
    output logic                      valid_o,
    output logic [clog2(NUM_REQ)-1:0] winner_o
);

    localparam int IW = clog2(NUM_REQ);
    localparam logic [IW:0] NUM_REQ_W = (IW+1)'(NUM_REQ);

    logic [NUM_REQ-1:0] rotated;
    logic [IW-1:0]      srcIdx;
    logic [IW-1:0]      offset;
    logic [IW:0]        sum;

    // Rotate so ptr_i lands on bit 0, find the lowest set bit, then map it back.
    always_comb begin
        rotated  = '0;
        srcIdx   = '0;
        offset   = '0;
        valid_o  = 1'b0;
        sum      = '0;
        winner_o = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            sum = {1'b0, ptr_i} + (IW+1)'(k);
            if (sum >= NUM_REQ_W) sum = sum - NUM_REQ_W;
            srcIdx     = sum[IW-1:0];
            rotated[k] = req_i[srcIdx];
        end
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (rotated[k]) begin
                valid_o = 1'b1;
                offset  = IW'(k);
            end
        end
        sum = {1'b0, ptr_i} + {1'b0, offset};
        if (sum >= NUM_REQ_W) sum = sum - NUM_REQ_W;
        winner_o = sum[IW-1:0];
    end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin arbiter sharing one server port between NUM_CLIENTS clients.
module bus_arbiter
    import bus_arb_pkg::*;
#(
    parameter int NUM_CLIENTS = DEFAULT_NUM_CLIENTS,
    parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
    parameter int ADDR_WIDTH  = DEFAULT_ADDR_WIDTH,
    parameter int TIMEOUT     = DEFAULT_TIMEOUT
)(
    input  logic                             clk,
    input  logic                             reset,
    input  logic [NUM_CLIENTS-1:0]           cl_rq,
    input  logic [NUM_CLIENTS-1:0]           cl_wr_ni,
    input  logic [NUM_CLIENTS*ADDR_WIDTH-1:0] cl_address,
    input  logic [NUM_CLIENTS*DATA_WIDTH-1:0] cl_dataW,
    output logic [NUM_CLIENTS-1:0]           cl_ack,
    output logic [NUM_CLIENTS-1:0]           cl_err,
    output logic [DATA_WIDTH-1:0]            cl_dataR,
    output logic                             srv_rq,
    output logic                             srv_wr_ni,
    output logic [ADDR_WIDTH-1:0]            srv_address,
    output logic [DATA_WIDTH-1:0]            srv_dataW,
    input  logic                             srv_ack,
    input  logic [DATA_WIDTH-1:0]            srv_dataR,
    output logic [clog2(NUM_CLIENTS)-1:0]    grant_id
);

    localparam int GW = clog2(NUM_CLIENTS);
    localparam int CW = clog2(TIMEOUT + 1);

    arbState_e              state_q;
    logic [GW-1:0]          rrPtr_q;
    logic [GW-1:0]          grant_q;
    logic [GW-1:0]          grantNext_d;
    logic [GW-1:0]          winner;
    logic                   selValid;
    logic [CW-1:0]          cnt_q;
    logic [CW-1:0]          cnt_d;
    logic                   srvRq_q;
    logic                   srvWr_q;
    logic [ADDR_WIDTH-1:0]  srvAddr_q;
    logic [DATA_WIDTH-1:0]  srvData_q;
    logic [NUM_CLIENTS-1:0] ack_q;
    logic [NUM_CLIENTS-1:0] err_q;
    logic [DATA_WIDTH-1:0]  dataR_q;
    logic [NUM_CLIENTS-1:0] grantOneHot;
    logic [ADDR_WIDTH-1:0]  addrArr [NUM_CLIENTS];
    logic [DATA_WIDTH-1:0]  dataArr [NUM_CLIENTS];

    // Unpack the client buses so the winning index can select its fields directly.
    always_comb begin
        for (int i = 0; i < NUM_CLIENTS; i++) begin
            addrArr[i] = cl_address[i*ADDR_WIDTH +: ADDR_WIDTH];
            dataArr[i] = cl_dataW[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    rr_priority_sel #(
        .NUM_REQ (NUM_CLIENTS)
    ) uSel (
        .req_i    (cl_rq),
        .ptr_i    (rrPtr_q),
        .valid_o  (selValid),
        .winner_o (winner)
    );

    assign cnt_d       = cnt_q + 1'b1;
    assign grantNext_d = (grant_q == GW'(NUM_CLIENTS - 1)) ? '0 : grant_q + 1'b1;
    assign grantOneHot = NUM_CLIENTS'(1) << grant_q;

    // Arbitration FSM: grant in IDLE, hold the server port in BUSY, wait for release in DONE.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            rrPtr_q   <= '0;
            grant_q   <= '0;
            cnt_q     <= '0;
            srvRq_q   <= 1'b0;
            srvWr_q   <= 1'b1;
            srvAddr_q <= '0;
            srvData_q <= '0;
            ack_q     <= '0;
            err_q     <= '0;
            dataR_q   <= '0;
        end else begin
            ack_q <= '0;
            err_q <= '0;
            unique case (state_q)
                IDLE: begin
                    if (selValid) begin
                        grant_q   <= winner;
                        srvAddr_q <= addrArr[winner];
                        srvData_q <= dataArr[winner];
                        srvWr_q   <= cl_wr_ni[winner];
                        srvRq_q   <= 1'b1;
                        cnt_q     <= '0;
                        state_q   <= BUSY;
                    end
                end
                BUSY: begin
                    if (srv_ack) begin
                        srvRq_q <= 1'b0;
                        ack_q   <= grantOneHot;
                        dataR_q <= srv_dataR;
                        state_q <= DONE;
                    end else if (cnt_d == CW'(TIMEOUT)) begin
                        srvRq_q <= 1'b0;
                        ack_q   <= grantOneHot;
                        err_q   <= grantOneHot;
                        dataR_q <= '0;
                        state_q <= DONE;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                DONE: begin
                    rrPtr_q <= grantNext_d;
                    if (!cl_rq[grant_q]) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign cl_ack      = ack_q;
    assign cl_err      = err_q;
    assign cl_dataR    = dataR_q;
    assign srv_rq      = srvRq_q;
    assign srv_wr_ni   = srvWr_q;
    assign srv_address = srvAddr_q;
    assign srv_dataW   = srvData_q;
    assign grant_id    = grant_q;

endmodule
